// File: rtl/his_builder_sched_pkg.sv
// Shared types for the histogram-builder acquisition scheduler.
// Also holds the modular-increment helper used by both the arbiter and the pointer update.
package his_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COARSE = 3'd1,
    S_SWITCH = 3'd2,
    S_FINE   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    PH_COARSE = 1'b0,
    PH_FINE   = 1'b1
  } phase_t;

  // (a + b) mod n for a < n and b <= n, which avoids a general divider.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/his_builder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i,
// scanning upward and wrapping around.
module rr_arbiter
  import his_sched_pkg::*;
#(
  parameter int PIXELS = 3
) (
  input  logic [PIXELS-1:0]         req_i,
  input  logic [$clog2(PIXELS)-1:0] ptr_i,
  output logic [PIXELS-1:0]         grant_o,
  output logic [$clog2(PIXELS)-1:0] idx_o,
  output logic                      any_grant_o
);

  localparam int IW = $clog2(PIXELS);

  int unsigned cand;

  // NOTE: every output gets a default before the scan so no path through the
  // block leaves a signal unassigned; an unassigned path would infer a latch.
  always_comb begin
    grant_o     = '0;
    idx_o       = '0;
    any_grant_o = 1'b0;
    cand        = 0;
    for (int k = 0; k < PIXELS; k++) begin
      cand = wrap_add(int'(ptr_i), k, PIXELS);
      if (!any_grant_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = IW'(cand);
        any_grant_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/his_builder_sched.sv
// Acquisition scheduler: round-robin shares one histogram-builder write port between
// PIXELS TDC streams, with a per-pixel quota, across COARSE and FINE acquisition phases.
module his_builder_sched
  import his_sched_pkg::*;
#(
  parameter int NP         = 10,
  parameter int PIXELS     = 3,
  parameter int ACQ_NUM    = 2,
  parameter int DATA_NUM   = 2,
  parameter int SWITCH_GAP = 2
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      start,
  input  logic                      abort,
  input  logic [PIXELS-1:0]         tdc_valid,
  input  logic [PIXELS*NP-1:0]      tdc_data,
  output logic [PIXELS-1:0]         tdc_ready,
  output logic                      wrEn,
  output logic [NP-1:0]             data,
  output logic [$clog2(PIXELS)-1:0] pix_sel,
  output logic                      phase,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int IW = $clog2(PIXELS);
  localparam int QW = $clog2(DATA_NUM + 1);
  localparam int AW = $clog2(ACQ_NUM + 1);
  localparam int GW = $clog2(SWITCH_GAP + 1);

  state_t        state_q, state_d;
  logic [QW-1:0] q_q [PIXELS];
  logic [QW-1:0] q_d [PIXELS];
  logic [AW-1:0] acq_q, acq_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] rr_q, rr_d;

  logic          wr_q;
  logic [NP-1:0] data_q;
  logic [IW-1:0] sel_q;
  phase_t        phase_q;

  logic              active;
  logic              xfer;
  logic              quota_met;
  logic [PIXELS-1:0] elig;
  logic [PIXELS-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              any_grant;
  logic [NP-1:0]     grant_data;

  // Grants are only offered while acquiring, and never in a cycle being aborted.
  always_comb begin
    active = ((state_q == S_COARSE) || (state_q == S_FINE)) && !abort;
    elig   = '0;
    for (int i = 0; i < PIXELS; i++) begin
      elig[i] = tdc_valid[i] && (q_q[i] < QW'(DATA_NUM));
    end
  end

  rr_arbiter #(
    .PIXELS (PIXELS)
  ) u_arb (
    .req_i       (elig),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .idx_o       (grant_idx),
    .any_grant_o (any_grant)
  );

  assign tdc_ready  = active ? grant : '0;
  assign xfer       = active && any_grant;
  assign grant_data = tdc_data[grant_idx*NP +: NP];

  always_comb begin
    state_d   = state_q;
    acq_d     = acq_q;
    gap_d     = gap_q;
    rr_d      = rr_q;
    quota_met = 1'b1;
    for (int i = 0; i < PIXELS; i++) begin
      q_d[i] = q_q[i];
      if (xfer && grant[i]) q_d[i] = q_q[i] + 1'b1;
      if (q_d[i] != QW'(DATA_NUM)) quota_met = 1'b0;
    end
    if (xfer) rr_d = IW'(wrap_add(int'(grant_idx), 1, PIXELS));

    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < PIXELS; i++) q_d[i] = '0;
        acq_d = '0;
        gap_d = '0;
        rr_d  = '0;
        if (start) state_d = S_COARSE;
      end
      S_COARSE, S_FINE: begin
        // quota_met already includes this cycle's transfer.
        if (quota_met) begin
          for (int i = 0; i < PIXELS; i++) q_d[i] = '0;
          if (acq_q == AW'(ACQ_NUM - 1)) begin
            acq_d   = '0;
            state_d = (state_q == S_COARSE) ? S_SWITCH : S_DONE;
          end else begin
            acq_d = acq_q + 1'b1;
          end
        end
      end
      S_SWITCH: begin
        rr_d = '0;
        if (gap_q == GW'(SWITCH_GAP - 1)) begin
          gap_d   = '0;
          state_d = S_FINE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      for (int i = 0; i < PIXELS; i++) q_d[i] = '0;
      acq_d = '0;
      gap_d = '0;
      rr_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      acq_q   <= '0;
      gap_q   <= '0;
      rr_q    <= '0;
      // NOTE: the quota array is a handful of flops, not a RAM, so it is reset
      // like any other register; a real memory array would be left unreset.
      for (int i = 0; i < PIXELS; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      for (int i = 0; i < PIXELS; i++) q_q[i] <= q_d[i];
    end
  end

  // Builder-facing output register; payload fields hold when no write occurs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_q    <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      phase_q <= PH_COARSE;
    end else begin
      wr_q <= xfer;
      if (xfer) begin
        data_q  <= grant_data;
        sel_q   <= grant_idx;
        phase_q <= (state_q == S_FINE) ? PH_FINE : PH_COARSE;
      end
    end
  end

  assign wrEn       = wr_q;
  assign data       = data_q;
  assign pix_sel    = sel_q;
  assign phase      = phase_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_his_builder_sched.sv
// Directed, table-driven bench for his_builder_sched at default parameters.
// Cycle c is the interval after clock edge c-1; inputs change just after the edge, outputs are sampled at the falling edge.
module tb_his_builder_sched;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic        abort;
  logic [2:0]  tdc_valid;
  logic [29:0] tdc_data;
  logic [2:0]  tdc_ready;
  logic        wrEn;
  logic [9:0]  data;
  logic [1:0]  pix_sel;
  logic        phase;
  logic        busy;
  logic        frame_done;

  typedef struct {
    logic        start;
    logic        abort;
    logic [2:0]  valid;
    logic [29:0] tdata;
    logic [2:0]  ready;
    logic        wr;
    logic [9:0]  dat;
    logic [1:0]  sel;
    logic        ph;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          vec_no   = 0;
  int          wr_cnt   = 0;
  int          ph1_cnt  = 0;
  logic [9:0]  h_data   = '0;
  logic [1:0]  h_sel    = '0;
  logic        h_ph     = 1'b0;

  his_builder_sched #(
    .NP(10), .PIXELS(3), .ACQ_NUM(2), .DATA_NUM(2), .SWITCH_GAP(2)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .abort      (abort),
    .tdc_valid  (tdc_valid),
    .tdc_data   (tdc_data),
    .tdc_ready  (tdc_ready),
    .wrEn       (wrEn),
    .data       (data),
    .pix_sel    (pix_sel),
    .phase      (phase),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tdc_ready"},  32'(tdc_ready),  32'd0);
    check({tag, " wrEn"},       32'(wrEn),       32'd0);
    check({tag, " data"},       32'(data),       32'd0);
    check({tag, " pix_sel"},    32'(pix_sel),    32'd0);
    check({tag, " phase"},      32'(phase),      32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic drive(input logic st, input logic ab, input logic [2:0] v, input logic [29:0] d);
    @(posedge clk);
    #1;
    start     = st;
    abort     = ab;
    tdc_valid = v;
    tdc_data  = d;
    @(negedge clk);
  endtask

  // Appends one cycle; per-pixel data is unique per vector so the registered
  // data can be traced back to the cycle and pixel it came from.
  function automatic void add(input logic st, input logic ab, input logic [2:0] v,
                              input logic [2:0] rdy, input logic wr, input logic [1:0] sel,
                              input logic ph, input logic bsy, input logic dn);
    vec_t e;
    e.start = st;
    e.abort = ab;
    e.valid = v;
    for (int i = 0; i < 3; i++) e.tdata[i*10 +: 10] = 10'(vec_no * 8 + i);
    if (wr) begin
      h_data = 10'((vec_no - 1) * 8 + int'(sel));
      h_sel  = sel;
      h_ph   = ph;
    end
    e.ready = rdy;
    e.wr    = wr;
    e.dat   = h_data;
    e.sel   = h_sel;
    e.ph    = h_ph;
    e.busy  = bsy;
    e.done  = dn;
    vecs.push_back(e);
    vec_no++;
  endfunction

  // Full-rate frame, start in cycle 0; abort_at < 0 means no abort.
  task automatic build_frame(input int abort_at);
    for (int c = 0; c <= 28; c++) begin
      logic [2:0] rdy;
      logic       wr;
      logic [1:0] sel;
      logic       ph;
      logic       live;
      logic       prev_live;
      int         t;
      t         = c - 1;
      rdy       = '0;
      wr        = 1'b0;
      sel       = '0;
      ph        = 1'b0;
      live      = (abort_at < 0) || (c < abort_at);
      prev_live = (abort_at < 0) || (t < abort_at);
      if (live && c >= 1 && c <= 12)  rdy = 3'(1 << ((c - 1) % 3));
      if (live && c >= 15 && c <= 26) rdy = 3'(1 << ((c - 15) % 3));
      if (prev_live && t >= 1 && t <= 12) begin
        wr  = 1'b1;
        sel = 2'((t - 1) % 3);
      end
      if (prev_live && t >= 15 && t <= 26) begin
        wr  = 1'b1;
        sel = 2'((t - 15) % 3);
        ph  = 1'b1;
      end
      add(c == 0, c == abort_at, 3'b111, rdy, wr, sel, ph,
          (c >= 1) && (c <= 27) && ((abort_at < 0) || (c <= abort_at)),
          (c == 27) && (abort_at < 0));
    end
  endtask

  task automatic run_vecs(input string tag);
    wr_cnt  = 0;
    ph1_cnt = 0;
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].start, vecs[k].abort, vecs[k].valid, vecs[k].tdata);
      if (wrEn) wr_cnt++;
      if (wrEn && phase) ph1_cnt++;
      check($sformatf("%s[%0d] tdc_ready", tag, k), 32'(tdc_ready), 32'(vecs[k].ready));
      check($sformatf("%s[%0d] wrEn", tag, k),      32'(wrEn),      32'(vecs[k].wr));
      check($sformatf("%s[%0d] data", tag, k),      32'(data),      32'(vecs[k].dat));
      check($sformatf("%s[%0d] pix_sel", tag, k),   32'(pix_sel),   32'(vecs[k].sel));
      check($sformatf("%s[%0d] phase", tag, k),     32'(phase),     32'(vecs[k].ph));
      check($sformatf("%s[%0d] busy", tag, k),      32'(busy),      32'(vecs[k].busy));
      check($sformatf("%s[%0d] frame_done", tag, k), 32'(frame_done), 32'(vecs[k].done));
    end
    vecs.delete();
  endtask

  initial begin
    logic [29:0] d4;
    logic [29:0] d6;
    d4 = {10'd108, 10'd0, 10'd0};
    d6 = {10'd202, 10'd201, 10'd200};

    // Reset held with random inputs.
    res       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    tdc_valid = '0;
    tdc_data  = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      start     = 1'($urandom);
      abort     = 1'($urandom);
      tdc_valid = 3'($urandom);
      tdc_data  = 30'($urandom);
      @(negedge clk);
      check_all_zero($sformatf("reset[%0d]", k));
    end
    start     = 1'b0;
    abort     = 1'b0;
    tdc_valid = '0;
    res       = 1'b0;

    // start together with abort in IDLE: abort wins.
    drive(1'b1, 1'b1, 3'b111, '0);
    check("start+abort busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 3'b111, '0);
    check("start+abort next busy", 32'(busy), 32'd0);
    check("start+abort next ready", 32'(tdc_ready), 32'd0);

    // Full-rate frame.
    build_frame(-1);
    run_vecs("frame");
    check("frame wrEn pulses", 32'(wr_cnt), 32'd24);
    check("frame fine pulses", 32'(ph1_cnt), 32'd12);

    // Quota back-pressure with only pixel 1 valid, then the others join.
    add(1, 0, 3'b010, 3'b000, 0, 2'd0, 0, 0, 0);
    add(0, 0, 3'b010, 3'b010, 0, 2'd0, 0, 1, 0);
    add(0, 0, 3'b010, 3'b010, 1, 2'd1, 0, 1, 0);
    add(0, 0, 3'b010, 3'b000, 1, 2'd1, 0, 1, 0);
    add(0, 0, 3'b010, 3'b000, 0, 2'd0, 0, 1, 0);
    add(0, 0, 3'b111, 3'b100, 0, 2'd0, 0, 1, 0);
    add(0, 0, 3'b111, 3'b001, 1, 2'd2, 0, 1, 0);
    add(0, 0, 3'b111, 3'b100, 1, 2'd0, 0, 1, 0);
    add(0, 0, 3'b111, 3'b001, 1, 2'd2, 0, 1, 0);
    add(0, 0, 3'b111, 3'b010, 1, 2'd0, 0, 1, 0);
    add(0, 1, 3'b111, 3'b000, 1, 2'd1, 0, 1, 0);
    add(0, 0, 3'b000, 3'b000, 0, 2'd0, 0, 0, 0);
    run_vecs("quota");

    // Data path: pixel 2 alone carrying 108.
    drive(1'b1, 1'b0, 3'b100, d4);
    check("dpath c0 busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 3'b100, d4);
    check("dpath c1 ready", 32'(tdc_ready), 32'b100);
    drive(1'b0, 1'b0, 3'b000, d4);
    check("dpath c2 wrEn", 32'(wrEn), 32'd1);
    check("dpath c2 data", 32'(data), 32'd108);
    check("dpath c2 pix_sel", 32'(pix_sel), 32'd2);
    check("dpath c2 phase", 32'(phase), 32'd0);
    drive(1'b0, 1'b1, 3'b000, d4);
    drive(1'b0, 1'b0, 3'b000, d4);
    check("dpath abort busy", 32'(busy), 32'd0);
    check("dpath abort wrEn", 32'(wrEn), 32'd0);
    h_data = 10'd108;
    h_sel  = 2'd2;
    h_ph   = 1'b0;

    // Abort during the second FINE acquisition, then a clean restart.
    build_frame(22);
    build_frame(-1);
    run_vecs("abort");

    // Asynchronous reset between clock edges mid-COARSE.
    drive(1'b1, 1'b0, 3'b111, d6);
    drive(1'b0, 1'b0, 3'b111, d6);
    drive(1'b0, 1'b0, 3'b111, d6);
    drive(1'b0, 1'b0, 3'b111, d6);
    check("async pre wrEn", 32'(wrEn), 32'd1);
    check("async pre data", 32'(data), 32'd201);
    check("async pre pix_sel", 32'(pix_sel), 32'd1);
    #2;
    res = 1'b1;
    #1;
    check_all_zero("async");
    @(posedge clk);
    @(negedge clk);
    res    = 1'b0;
    h_data = '0;
    h_sel  = '0;
    h_ph   = 1'b0;
    build_frame(-1);
    run_vecs("post_reset");
    check("post_reset wrEn pulses", 32'(wr_cnt), 32'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
